delta_sigma_decimator: RTL

Receive-side counterpart to delta_sigma_dac. Takes a 1-bit pulse-density stream in the clk domain and reconstructs an 8-bit sample once per decimation window of 2^DECIM_LOG2 clocks. Used for loopback verification of the oscillator→DAC chain and as the front end for an external sigma-delta modulator input. The default filter is a boxcar (sinc1) integrate-and-dump. An optional sinc2 (CIC order 2) filter can be compiled in.

---
 rtl/delta_sigma_decimator.sv | 126 ++++++++++++
 1 files changed

// File: rtl/delta_sigma_decimator.sv
// Pulse-density to 8-bit decimator: boxcar integrate-and-dump over 2^DECIM_LOG2 clocks.
// Define DECIMATOR_SINC2_EN to replace the boxcar with a 2nd-order CIC (sinc2) filter.
module delta_sigma_decimator #(
  parameter int DECIM_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  bit_in,
  output logic [7:0]            data_out,
  output logic                  data_valid,
  output logic                  clipped,
  output logic [DECIM_LOG2-1:0] window_pos
);

  localparam int N = DECIM_LOG2;

  logic [N-1:0] pos_q, pos_d;
  logic [7:0]   dout_q, dout_d;
  logic         valid_q, valid_d;
  logic         clip_q, clip_d;
  logic         win_end;
  logic         emit;
  logic [8:0]   scaled;

  assign win_end = enable && (pos_q == '1);

`ifdef DECIMATOR_SINC2_EN
  localparam int W = 2 * N + 1;

  logic [W-1:0] i1_q, i1_d, i2_q, i2_d;
  logic [W-1:0] i2z_q, i2z_d, c1z_q, c1z_d;
  logic [W-1:0] i1_n, i2_n, c1, y;
  logic [1:0]   fill_q, fill_d;

  // Integrators run continuously (modular); combs only advance at window end.
  always_comb begin
    i1_n   = i1_q + W'(bit_in);
    i2_n   = i2_q + i1_n;
    c1     = i2_n - i2z_q;
    y      = c1 - c1z_q;
    scaled = 9'(y >> (2 * N - 8));
    emit   = win_end && (fill_q == 2'd2);
    i1_d   = '0;
    i2_d   = '0;
    i2z_d  = '0;
    c1z_d  = '0;
    fill_d = 2'd0;
    if (enable) begin
      i1_d   = i1_n;
      i2_d   = i2_n;
      i2z_d  = i2z_q;
      c1z_d  = c1z_q;
      fill_d = fill_q;
      if (win_end) begin
        i2z_d = i2_n;
        c1z_d = c1;
        if (fill_q != 2'd2) fill_d = fill_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1_q   <= '0;
      i2_q   <= '0;
      i2z_q  <= '0;
      c1z_q  <= '0;
      fill_q <= 2'd0;
    end else begin
      i1_q   <= i1_d;
      i2_q   <= i2_d;
      i2z_q  <= i2z_d;
      c1z_q  <= c1z_d;
      fill_q <= fill_d;
    end
  end
`else
  logic [N:0] cnt_q, cnt_d, total;

  // The last sample of the window is folded in on the dump edge itself.
  always_comb begin
    total  = cnt_q + {{N{1'b0}}, bit_in};
    scaled = 9'(total >> (N - 8));
    emit   = win_end;
    cnt_d  = '0;
    if (enable && !win_end) cnt_d = total;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    pos_d   = enable ? pos_q + N'(1) : '0;
    valid_d = emit;
    dout_d  = dout_q;
    clip_d  = clip_q;
    if (emit) begin
      dout_d = scaled[8] ? 8'hFF : scaled[7:0];
      clip_d = scaled[8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q   <= '0;
      dout_q  <= 8'h00;
      valid_q <= 1'b0;
      clip_q  <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      clip_q  <= clip_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign clipped    = clip_q;
  assign window_pos = pos_q;

endmodule
